dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 10, data-memory word-address width.
REQ-002 Parameter DATA_W, default 32, data word width.
REQ-003 Parameter MAX_WAIT, default 8, maximum cycles the core may be denied while the loader holds a lock.
REQ-004 clk  in  1  single system clock; all state updates on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 core_req  in  1  core load/store request, held until granted.
REQ-007 core_we  in  1  core write enable (1 store, 0 load).
REQ-008 core_addr  in  ADDR_W  core word address.
REQ-009 core_wdata  in  DATA_W  core store data.
REQ-010 core_gnt  out  1  core request accepted this cycle.
REQ-011 core_rvalid  out  1  core read data valid.
REQ-012 core_rdata  out  DATA_W  core read data.
REQ-013 ld_req, ld_we, ld_addr, ld_wdata, ld_gnt, ld_rvalid, ld_rdata: loader port, same widths and meanings as core port.
REQ-014 ld_lock  in  1  loader requests exclusive burst ownership.
REQ-015 mem_en  out  1  memory access strobe.
REQ-016 mem_we  out  1  memory write enable.
REQ-017 mem_addr  out  ADDR_W  memory address.
REQ-018 mem_wdata  out  DATA_W  memory write data.
REQ-019 mem_rdata  in  DATA_W  synchronous-read memory data, valid one cycle after mem_en with mem_we=0.

Function
REQ-020 Grants, mem_en, mem_we, mem_addr and mem_wdata SHALL be combinational from current requests and state; at most one grant per cycle.
REQ-021 FSM states SHALL be RR (round-robin) and LOCKED.
REQ-022 In RR, single requester SHALL be granted; on simultaneous requests, the requester not granted last SHALL win; last-grant pointer updates on every grant.
REQ-023 In RR, a loader grant with ld_lock=1 SHALL transition to LOCKED next cycle.
REQ-024 In LOCKED, only the loader SHALL be granted; the state SHALL return to RR when ld_lock=0 or on forced core grant.
REQ-025 Wait counter SHALL increment each LOCKED cycle with core_req=1 and no core grant, saturating at MAX_WAIT, and clear on any core grant or when core_req=0.
REQ-026 When wait counter equals MAX_WAIT in LOCKED, the core SHALL be granted that cycle regardless of ld_req, the loader denied, and state SHALL go to RR with last-grant = core.
REQ-027 Granted reads SHALL raise that port's rvalid exactly one cycle after grant, with rdata = mem_rdata; rvalid SHALL not assert for writes.
REQ-028 core_rdata/ld_rdata SHALL be driven by mem_rdata only when the respective rvalid is set, else zero.
REQ-029 mem_en=0 with no grant; mem_we/addr/wdata SHALL then be zero.
REQ-030 Back-to-back grants SHALL be allowed every cycle (throughput 1 access/cycle).

Reset
REQ-031 rst SHALL force state RR, last-grant = loader (core wins first tie), wait counter 0, and clear both rvalid flags, immediately and independent of clk.
REQ-032 A read granted in the cycle reset asserts SHALL produce no rvalid.

Structure
REQ-033 FSM state encoding and port-select constants (SEL_CORE, SEL_LD) SHALL live in shared package kgp_risc_pkg.
REQ-034 Priority selection SHALL be one sub-module, rr_arb2 (two requests, last-grant pointer in, one-hot grant out); FSM, counter and read-return tracking stay in dmem_arbiter.

Verification
REQ-035 Only core_req=1, we=0, addr=5, memory[5]=0xDEADBEEF -> core_gnt same cycle; core_rvalid=1, core_rdata=0xDEADBEEF next cycle.
REQ-036 After reset, both req held 4 cycles -> grants alternate core, ld, core, ld.
REQ-037 ld_req=ld_lock=1 for 20 cycles, core_req=1 throughout, MAX_WAIT=8 -> loader granted first, core granted on 10th cycle, loader resumes after.
REQ-038 ld_lock dropped after 3 locked cycles, core_req=1 -> state RR, core granted next cycle.
REQ-039 rst asserted mid-clock during read grant -> rvalid stays 0, state RR, counter 0 without clock edge.
REQ-040 Core write addr=3 data=0x12 then loader read addr=3 -> ld_rdata=0x12 with ld_rvalid one cycle after loader grant.

Source files
------------

// File: rtl/kgp_risc_pkg.sv
// Shared types for the data-memory arbiter: arbiter FSM encoding and port-select ids.
package kgp_risc_pkg;

  typedef enum logic {
    StRr     = 1'b0,
    StLocked = 1'b1
  } arb_state_e;

  typedef logic port_sel_t;

  localparam port_sel_t SEL_CORE = 1'b0;
  localparam port_sel_t SEL_LD   = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to whoever was not granted last.
module rr_arb2
  import kgp_risc_pkg::*;
(
  input  logic [1:0] req_i,
  input  port_sel_t  last_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = '0;
    if (req_i[SEL_CORE] && (!req_i[SEL_LD] || (last_i == SEL_LD))) begin
      gnt_o[SEL_CORE] = 1'b1;
    end else if (req_i[SEL_LD]) begin
      gnt_o[SEL_LD] = 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Core/loader data-memory arbiter: round-robin sharing, loader burst lock with bounded
// core starvation, and one-cycle read-return steering.
module dmem_arbiter
  import kgp_risc_pkg::*;
#(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_gnt,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  input  logic              ld_lock,
  output logic              ld_gnt,
  output logic              ld_rvalid,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned    WaitW   = $clog2(MAX_WAIT + 1);
  localparam logic [WaitW-1:0] WaitMax = WaitW'(MAX_WAIT);

  arb_state_e       state_q, state_d;
  port_sel_t        last_q, last_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic             core_rv_q, ld_rv_q;
  logic [1:0]       rr_req, rr_gnt;
  logic             force_core;

  assign rr_req = {ld_req, core_req};

  rr_arb2 u_rr_arb2 (
    .req_i  (rr_req),
    .last_i (last_q),
    .gnt_o  (rr_gnt)
  );

  // Core has starved for MAX_WAIT locked cycles: it takes this slot and breaks the lock.
  assign force_core = (state_q == StLocked) && core_req && (wait_q == WaitMax);

  always_comb begin
    core_gnt = 1'b0;
    ld_gnt   = 1'b0;
    state_d  = state_q;
    last_d   = last_q;
    wait_d   = '0;
    unique case (state_q)
      StRr: begin
        core_gnt = rr_gnt[SEL_CORE];
        ld_gnt   = rr_gnt[SEL_LD];
        if (ld_gnt && ld_lock) state_d = StLocked;
      end
      StLocked: begin
        if (force_core) begin
          core_gnt = 1'b1;
          state_d  = StRr;
        end else begin
          ld_gnt = ld_req;
          if (!ld_lock) state_d = StRr;
          if (core_req) wait_d = (wait_q == WaitMax) ? wait_q : wait_q + 1'b1;
        end
      end
      default: state_d = StRr;
    endcase
    if (core_gnt) begin
      last_d = SEL_CORE;
    end else if (ld_gnt) begin
      last_d = SEL_LD;
    end
  end

  always_comb begin
    mem_en    = core_gnt | ld_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (core_gnt) begin
      mem_we    = core_we;
      mem_addr  = core_addr;
      mem_wdata = core_wdata;
    end else if (ld_gnt) begin
      mem_we    = ld_we;
      mem_addr  = ld_addr;
      mem_wdata = ld_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StRr;
      last_q    <= SEL_LD;
      wait_q    <= '0;
      core_rv_q <= 1'b0;
      ld_rv_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      wait_q    <= wait_d;
      core_rv_q <= core_gnt & ~core_we;
      ld_rv_q   <= ld_gnt & ~ld_we;
    end
  end

  assign core_rvalid = core_rv_q;
  assign ld_rvalid   = ld_rv_q;
  assign core_rdata  = core_rv_q ? mem_rdata : '0;
  assign ld_rdata    = ld_rv_q ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a behavioural grant/memory model checked every cycle,
// plus hand-computed expectations for the key scenarios.
module tb_dmem_arbiter;
  import kgp_risc_pkg::*;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 32;
  localparam int unsigned MW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          core_req = 1'b0, core_we = 1'b0;
  logic [AW-1:0] core_addr = '0;
  logic [DW-1:0] core_wdata = '0;
  logic          ld_req = 1'b0, ld_we = 1'b0, ld_lock = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [DW-1:0] ld_wdata = '0;
  logic          core_gnt, core_rvalid, ld_gnt, ld_rvalid;
  logic [DW-1:0] core_rdata, ld_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [DW-1:0] mem [1024];

  int checks = 0;
  int failures = 0;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
    .clk        (clk),
    .rst        (rst),
    .core_req   (core_req),
    .core_we    (core_we),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_gnt   (core_gnt),
    .core_rvalid(core_rvalid),
    .core_rdata (core_rdata),
    .ld_req     (ld_req),
    .ld_we      (ld_we),
    .ld_addr    (ld_addr),
    .ld_wdata   (ld_wdata),
    .ld_lock    (ld_lock),
    .ld_gnt     (ld_gnt),
    .ld_rvalid  (ld_rvalid),
    .ld_rdata   (ld_rdata),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM behind the arbiter.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model state
  bit            m_locked, m_last_core, m_pc, m_pl, m_forced, m_was_locked, e_c, e_l, e_we;
  int unsigned   m_wait;
  logic [DW-1:0] m_pdc, m_pdl, e_d;
  logic [AW-1:0] e_a;
  logic [DW-1:0] m_shadow [1024];

  task automatic model_reset();
    m_locked = 1'b0;
    m_last_core = 1'b0;
    m_wait = 0;
    m_pc = 1'b0;
    m_pl = 1'b0;
  endtask

  initial begin : compare
    model_reset();
    forever begin
      @(negedge clk or posedge rst);
      if (rst) begin
        model_reset();
      end else begin
        check("core_rvalid", core_rvalid, m_pc);
        check("core_rdata", core_rdata, m_pc ? m_pdc : '0);
        check("ld_rvalid", ld_rvalid, m_pl);
        check("ld_rdata", ld_rdata, m_pl ? m_pdl : '0);
        m_forced = m_locked && core_req && (m_wait >= MW);
        if (m_forced) begin
          e_c = 1'b1; e_l = 1'b0;
        end else if (m_locked) begin
          e_c = 1'b0; e_l = ld_req;
        end else if (core_req && ld_req) begin
          e_c = !m_last_core; e_l = m_last_core;
        end else begin
          e_c = core_req; e_l = ld_req;
        end
        e_we = e_c ? core_we : (e_l ? ld_we : 1'b0);
        e_a  = e_c ? core_addr : (e_l ? ld_addr : '0);
        e_d  = e_c ? core_wdata : (e_l ? ld_wdata : '0);
        check("core_gnt", core_gnt, e_c);
        check("ld_gnt", ld_gnt, e_l);
        check("mem_en", mem_en, e_c | e_l);
        check("mem_we", mem_we, e_we);
        check("mem_addr", mem_addr, e_a);
        check("mem_wdata", mem_wdata, e_d);
        m_pc = e_c && !core_we;
        m_pl = e_l && !ld_we;
        if (m_pc) m_pdc = m_shadow[core_addr];
        if (m_pl) m_pdl = m_shadow[ld_addr];
        if ((e_c || e_l) && e_we) m_shadow[e_a] = e_d;
        if (e_c || e_l) m_last_core = e_c;
        m_was_locked = m_locked;
        if (!m_locked)     m_locked = e_l && ld_lock;
        else if (m_forced) m_locked = 1'b0;
        else               m_locked = ld_lock;
        if (m_was_locked && !m_forced && core_req) m_wait = (m_wait < MW) ? m_wait + 1 : MW;
        else m_wait = 0;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic cr, input logic cw, input logic [AW-1:0] ca,
                       input logic [DW-1:0] cd, input logic lr, input logic lw,
                       input logic [AW-1:0] la, input logic [DW-1:0] ldd, input logic lk);
    core_req = cr; core_we = cw; core_addr = ca; core_wdata = cd;
    ld_req = lr; ld_we = lw; ld_addr = la; ld_wdata = ldd; ld_lock = lk;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin : stim
    bit exp_core;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    at_neg();
    check("rst_state", dut.state_q, StRr);
    check("rst_wait", dut.wait_q, 0);
    check("rst_core_rvalid", core_rvalid, 0);
    check("rst_ld_rvalid", ld_rvalid, 0);
    check("rst_mem_en", mem_en, 0);

    // Both ports hold write requests: grants alternate, core first.
    step();
    drive(1, 1, 10'd1, 32'h11, 1, 1, 10'd2, 32'h22, 0);
    for (int i = 0; i < 4; i++) begin
      at_neg();
      check("alt_core_gnt", core_gnt, (i % 2) == 0);
      check("alt_ld_gnt", ld_gnt, (i % 2) == 1);
      step();
    end

    // Core store then load of address 5.
    drive(1, 1, 10'd5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    at_neg();
    check("wr5_core_gnt", core_gnt, 1);
    step();
    drive(1, 0, 10'd5, 0, 0, 0, 0, 0, 0);
    at_neg();
    check("rd5_core_gnt", core_gnt, 1);
    check("wr_no_rvalid", core_rvalid, 0);
    step();
    idle();
    at_neg();
    check("rd5_rvalid", core_rvalid, 1);
    check("rd5_rdata", core_rdata, 32'hDEADBEEF);
    step();

    // Core store 0x12 to address 3, loader reads it back.
    drive(1, 1, 10'd3, 32'h12, 0, 0, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 1, 0, 10'd3, 0, 0);
    at_neg();
    check("ld3_gnt", ld_gnt, 1);
    step();
    idle();
    at_neg();
    check("ld3_rvalid", ld_rvalid, 1);
    check("ld3_rdata", ld_rdata, 32'h12);
    check("ld3_core_rdata", core_rdata, 0);
    step();

    // Lone core access so the loader wins the next tie, then a 20-cycle locked burst.
    drive(1, 0, 10'd5, 0, 0, 0, 0, 0, 0);
    step();
    drive(1, 0, 10'd5, 0, 1, 0, 10'd3, 0, 1);
    for (int c = 1; c <= 20; c++) begin
      at_neg();
      exp_core = (c == 10) || (c == 20);
      check("lock_core_gnt", core_gnt, exp_core);
      check("lock_ld_gnt", ld_gnt, !exp_core);
      if (c == 10) check("lock_wait_sat", dut.wait_q, MW);
      step();
    end

    // Lock dropped after three locked cycles.
    for (int c = 1; c <= 4; c++) begin
      at_neg();
      check("drop_ld_gnt", ld_gnt, 1);
      step();
    end
    drive(1, 0, 10'd5, 0, 1, 0, 10'd3, 0, 0);
    at_neg();
    check("drop_still_locked", dut.state_q, StLocked);
    check("drop_last_ld_gnt", ld_gnt, 1);
    step();
    at_neg();
    check("drop_state_rr", dut.state_q, StRr);
    check("drop_core_gnt", core_gnt, 1);
    step();
    idle();
    step();

    // Asynchronous reset mid-cycle while a locked loader read is in flight.
    drive(1, 0, 10'd5, 0, 1, 0, 10'd3, 0, 1);
    for (int c = 1; c <= 3; c++) begin
      at_neg();
      step();
    end
    at_neg();
    check("pre_rst_locked", dut.state_q, StLocked);
    check("pre_rst_wait", dut.wait_q, 2);
    check("pre_rst_ld_rvalid", ld_rvalid, 1);
    #1 rst = 1'b1;
    #1;
    check("arst_ld_rvalid", ld_rvalid, 0);
    check("arst_core_rvalid", core_rvalid, 0);
    check("arst_state", dut.state_q, StRr);
    check("arst_wait", dut.wait_q, 0);
    step();
    check("rst_edge_ld_rvalid", ld_rvalid, 0);
    check("rst_edge_core_rvalid", core_rvalid, 0);
    rst = 1'b0;
    idle();
    at_neg();
    check("post_rst_core_rvalid", core_rvalid, 0);
    check("post_rst_ld_rvalid", ld_rvalid, 0);
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
